result_byte_sequencer: RTL and testbench

RESULT_BYTE_SEQUENCER -- requirements
Module: result_byte_sequencer

---
 rtl/result_byte_sequencer_pkg.sv | 26 ++
 rtl/result_byte_sequencer_btn_sync_edge.sv | 29 ++
 rtl/result_byte_sequencer.sv | 86 ++++++++
 tb/tb_result_byte_sequencer.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/result_byte_sequencer_pkg.sv
// Shared types and constants for the result byte sequencer: FSM state
// encoding, dwell counter width and a byte-select helper for the
// 32-bit holding register.
package result_byte_sequencer_pkg;

  localparam int DWELL_W = 24;

  typedef enum logic {
    IDLE = 1'b0,
    SHOW = 1'b1
  } seq_state_t;

  // Byte 3 is the most significant byte of the word, byte 0 the least.
  function automatic logic [7:0] select_byte(input logic [31:0] word,
                                             input logic [1:0]  idx);
    logic [7:0] sel;
    case (idx)
      2'd3:    sel = word[31:24];
      2'd2:    sel = word[23:16];
      2'd1:    sel = word[15:8];
      default: sel = word[7:0];
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/result_byte_sequencer_btn_sync_edge.sv
// Brings the raw push-button level into the clk domain through two flops
// and turns each rising edge into a single-cycle pulse.
module btn_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic pulse
);

  logic sync1;
  logic sync2;
  logic prev;

  // Two-stage synchronizer followed by one history flop for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign pulse = sync2 & ~prev;

endmodule

// File: rtl/result_byte_sequencer.sv
// Shows a 32-bit FPU result one byte at a time (MSB first) on a two-digit
// seven-segment driver. Bytes advance either on a dwell timer (auto mode)
// or on debounced-upstream step button presses (manual mode).
module result_byte_sequencer
  import result_byte_sequencer_pkg::*;
#(
  parameter int unsigned DWELL_CYCLES = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  input  logic        auto_mode,
  input  logic        step_btn,
  output logic        in_ready,
  output logic [7:0]  char,
  output logic [1:0]  byte_idx,
  output logic        done
);

  localparam logic [DWELL_W-1:0] DWELL_LOAD = DWELL_W'(DWELL_CYCLES - 1);

  seq_state_t         state;
  logic [31:0]        hold;
  logic [DWELL_W-1:0] dwell;
  logic               auto_q;
  logic               step_pulse;
  logic               advance;

  btn_sync_edge u_btn (
    .clk   (clk),
    .rst   (rst),
    .btn   (step_btn),
    .pulse (step_pulse)
  );

  // The advance condition depends only on flops, so done carries no
  // combinational path from the data or mode inputs. Button pulses that
  // arrive in IDLE or while in auto mode fall through and are lost.
  assign advance  = (state == SHOW) && (auto_q ? (dwell == '0) : step_pulse);
  assign done     = advance && (byte_idx == 2'd0) && !rst;
  assign in_ready = (state == IDLE);

  // Load/advance FSM; the mode is registered so a switch lands one cycle
  // later, and any cycle spent in manual mode re-arms a full dwell.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      hold     <= '0;
      char     <= 8'h00;
      byte_idx <= 2'd3;
      dwell    <= DWELL_LOAD;
      auto_q   <= 1'b0;
    end else begin
      auto_q <= auto_mode;
      case (state)
        IDLE: begin
          dwell <= DWELL_LOAD;
          if (in_valid) begin
            hold     <= in_data;
            state    <= SHOW;
            byte_idx <= 2'd3;
            char     <= in_data[31:24];
          end
        end
        SHOW: begin
          if (advance) begin
            dwell <= DWELL_LOAD;
            if (byte_idx == 2'd0) begin
              state <= IDLE;
            end else begin
              byte_idx <= byte_idx - 2'd1;
              char     <= select_byte(hold, byte_idx - 2'd1);
            end
          end else if (!auto_q) begin
            dwell <= DWELL_LOAD;
          end else begin
            dwell <= dwell - DWELL_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_result_byte_sequencer.sv
// Directed bench for result_byte_sequencer with a short dwell of 4 cycles.
// Inputs are driven and outputs sampled on the falling edge.
module tb_result_byte_sequencer;

  localparam int DWELL = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_data;
  logic        auto_mode;
  logic        step_btn;
  logic        in_ready;
  logic [7:0]  char;
  logic [1:0]  byte_idx;
  logic        done;

  int n_compared   = 0;
  int n_mismatched = 0;

  always #5 clk = ~clk;

  result_byte_sequencer #(.DWELL_CYCLES(DWELL)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .auto_mode (auto_mode),
    .step_btn  (step_btn),
    .in_ready  (in_ready),
    .char      (char),
    .byte_idx  (byte_idx),
    .done      (done)
  );

  // Presents a word for one cycle; returns at the falling edge of cycle 1.
  task automatic load_word(input logic [31:0] w);
    in_valid = 1'b1;
    in_data  = w;
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 32'h0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_data = 32'h0; auto_mode = 1'b1; step_btn = 1'b0;
    repeat (2) @(negedge clk);
    n_compared++; if (char !== 8'h00) begin n_mismatched++; $display("[TB] FAIL reset_char got %h want 00", char); end
    n_compared++; if (byte_idx !== 2'd3) begin n_mismatched++; $display("[TB] FAIL reset_idx got %0d want 3", byte_idx); end
    n_compared++; if (done !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_done got %b want 0", done); end
    n_compared++; if (in_ready !== 1'b1) begin n_mismatched++; $display("[TB] FAIL reset_ready got %b want 1", in_ready); end
    rst = 1'b0;
    @(negedge clk);
    n_compared++; if (in_ready !== 1'b1) begin n_mismatched++; $display("[TB] FAIL post_reset_ready got %b want 1", in_ready); end
  endtask

  task automatic test_auto_sequence();
    logic [7:0] exp_bytes [4];
    exp_bytes = '{8'h3F, 8'h80, 8'h00, 8'h00};
    auto_mode = 1'b1;
    load_word(32'h3F80_0000);
    for (int c = 1; c <= 16; c++) begin
      n_compared++; if (char !== exp_bytes[(c-1)/4]) begin n_mismatched++; $display("[TB] FAIL auto_char c%0d got %h want %h", c, char, exp_bytes[(c-1)/4]); end
      n_compared++; if (byte_idx !== 2'(3 - (c-1)/4)) begin n_mismatched++; $display("[TB] FAIL auto_idx c%0d got %0d want %0d", c, byte_idx, 3 - (c-1)/4); end
      n_compared++; if (done !== (c == 16)) begin n_mismatched++; $display("[TB] FAIL auto_done c%0d got %b want %b", c, done, (c == 16)); end
      n_compared++; if (in_ready !== 1'b0) begin n_mismatched++; $display("[TB] FAIL auto_ready c%0d got %b want 0", c, in_ready); end
      @(negedge clk);
    end
    n_compared++; if (in_ready !== 1'b1) begin n_mismatched++; $display("[TB] FAIL auto_end_ready got %b want 1", in_ready); end
    n_compared++; if (done !== 1'b0) begin n_mismatched++; $display("[TB] FAIL auto_end_done got %b want 0", done); end
    n_compared++; if (char !== 8'h00 || byte_idx !== 2'd0) begin n_mismatched++; $display("[TB] FAIL auto_end_hold got %h/%0d want 00/0", char, byte_idx); end
  endtask

  // One button press: old byte persists two edges, done pulses with the
  // synchronized edge on the last byte, new byte appears on the third edge.
  task automatic press_step(input logic [7:0] old_char, input logic [7:0] new_char,
                            input logic [1:0] new_idx, input logic last);
    step_btn = 1'b1;
    @(negedge clk);
    n_compared++; if (char !== old_char) begin n_mismatched++; $display("[TB] FAIL step_e1_char got %h want %h", char, old_char); end
    @(negedge clk);
    n_compared++; if (char !== old_char) begin n_mismatched++; $display("[TB] FAIL step_e2_char got %h want %h", char, old_char); end
    n_compared++; if (done !== last) begin n_mismatched++; $display("[TB] FAIL step_done got %b want %b", done, last); end
    @(negedge clk);
    n_compared++; if (char !== new_char) begin n_mismatched++; $display("[TB] FAIL step_e3_char got %h want %h", char, new_char); end
    n_compared++; if (byte_idx !== new_idx) begin n_mismatched++; $display("[TB] FAIL step_e3_idx got %0d want %0d", byte_idx, new_idx); end
    n_compared++; if (in_ready !== last || done !== 1'b0) begin n_mismatched++; $display("[TB] FAIL step_e3_state got ready=%b done=%b want ready=%b done=0", in_ready, done, last); end
    step_btn = 1'b0;
    repeat (4) @(negedge clk);
    n_compared++; if (char !== new_char || byte_idx !== new_idx) begin n_mismatched++; $display("[TB] FAIL step_settle got %h/%0d want %h/%0d", char, byte_idx, new_char, new_idx); end
  endtask

  task automatic test_manual();
    auto_mode = 1'b0;
    step_btn  = 1'b1;
    repeat (3) @(negedge clk);
    n_compared++; if (in_ready !== 1'b1 || done !== 1'b0) begin n_mismatched++; $display("[TB] FAIL idle_btn got ready=%b done=%b want 1/0", in_ready, done); end
    step_btn = 1'b0;
    repeat (3) @(negedge clk);
    load_word(32'hC049_0FDB);
    for (int c = 1; c <= 6; c++) begin
      n_compared++; if (char !== 8'hC0 || byte_idx !== 2'd3 || done !== 1'b0) begin n_mismatched++; $display("[TB] FAIL manual_hold c%0d got %h/%0d/%b want C0/3/0", c, char, byte_idx, done); end
      @(negedge clk);
    end
    press_step(8'hC0, 8'h49, 2'd2, 1'b0);
    press_step(8'h49, 8'h0F, 2'd1, 1'b0);
    press_step(8'h0F, 8'hDB, 2'd0, 1'b0);
    press_step(8'hDB, 8'hDB, 2'd0, 1'b1);
  endtask

  task automatic test_ignore_in_valid();
    logic [7:0] exp_bytes [4];
    exp_bytes = '{8'hAA, 8'hAA, 8'hBB, 8'hBB};
    auto_mode = 1'b1;
    repeat (2) @(negedge clk);
    load_word(32'hAAAA_BBBB);
    for (int c = 1; c <= 16; c++) begin
      n_compared++; if (char !== exp_bytes[(c-1)/4]) begin n_mismatched++; $display("[TB] FAIL busy_char c%0d got %h want %h", c, char, exp_bytes[(c-1)/4]); end
      n_compared++; if (in_ready !== 1'b0 || done !== (c == 16)) begin n_mismatched++; $display("[TB] FAIL busy_ctrl c%0d got ready=%b done=%b want 0/%b", c, in_ready, done, (c == 16)); end
      if (c == 3) begin
        in_valid = 1'b1;
        in_data  = 32'h1234_5678;
      end
      @(negedge clk);
    end
    n_compared++; if (in_ready !== 1'b1 || char !== 8'hBB) begin n_mismatched++; $display("[TB] FAIL busy_after_done got ready=%b char=%h want 1/BB", in_ready, char); end
    @(negedge clk);
    in_valid = 1'b0;
    n_compared++; if (char !== 8'h12 || byte_idx !== 2'd3 || in_ready !== 1'b0) begin n_mismatched++; $display("[TB] FAIL busy_reload got %h/%0d/%b want 12/3/0", char, byte_idx, in_ready); end
    do_reset();
  endtask

  task automatic test_reset_mid();
    auto_mode = 1'b1;
    load_word(32'h1122_3344);
    repeat (8) @(negedge clk);
    n_compared++; if (byte_idx !== 2'd1 || char !== 8'h33) begin n_mismatched++; $display("[TB] FAIL mid_pre got %h/%0d want 33/1", char, byte_idx); end
    rst = 1'b1;
    n_compared++; if (done !== 1'b0) begin n_mismatched++; $display("[TB] FAIL mid_rst_done got %b want 0", done); end
    @(negedge clk);
    n_compared++; if (char !== 8'h00 || byte_idx !== 2'd3) begin n_mismatched++; $display("[TB] FAIL mid_post got %h/%0d want 00/3", char, byte_idx); end
    n_compared++; if (in_ready !== 1'b1 || done !== 1'b0) begin n_mismatched++; $display("[TB] FAIL mid_post_ctrl got ready=%b done=%b want 1/0", in_ready, done); end
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_compared++; if (done !== 1'b0 || in_ready !== 1'b1) begin n_mismatched++; $display("[TB] FAIL mid_idle c%0d got done=%b ready=%b want 0/1", c, done, in_ready); end
    end
    load_word(32'hDEAD_BEEF);
    n_compared++; if (char !== 8'hDE || byte_idx !== 2'd3 || in_ready !== 1'b0) begin n_mismatched++; $display("[TB] FAIL mid_reload got %h/%0d/%b want DE/3/0", char, byte_idx, in_ready); end
    repeat (4) @(negedge clk);
    n_compared++; if (char !== 8'hAD || byte_idx !== 2'd2) begin n_mismatched++; $display("[TB] FAIL mid_reload_adv got %h/%0d want AD/2", char, byte_idx); end
    do_reset();
  endtask

  task automatic test_mode_switch();
    auto_mode = 1'b1;
    load_word(32'h0102_0304);
    repeat (4) @(negedge clk);
    n_compared++; if (byte_idx !== 2'd2 || char !== 8'h02) begin n_mismatched++; $display("[TB] FAIL sw_pre got %h/%0d want 02/2", char, byte_idx); end
    auto_mode = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      n_compared++; if (byte_idx !== 2'd2 || char !== 8'h02 || done !== 1'b0) begin n_mismatched++; $display("[TB] FAIL sw_hold c%0d got %h/%0d/%b want 02/2/0", c, char, byte_idx, done); end
    end
    press_step(8'h02, 8'h03, 2'd1, 1'b0);
    auto_mode = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      n_compared++; if (byte_idx !== 2'd1 || char !== 8'h03) begin n_mismatched++; $display("[TB] FAIL sw_dwell k%0d got %h/%0d want 03/1", k, char, byte_idx); end
    end
    @(negedge clk);
    n_compared++; if (byte_idx !== 2'd0 || char !== 8'h04 || done !== 1'b0) begin n_mismatched++; $display("[TB] FAIL sw_adv got %h/%0d/%b want 04/0/0", char, byte_idx, done); end
    for (int k = 2; k <= 4; k++) begin
      @(negedge clk);
      n_compared++; if (done !== (k == 4)) begin n_mismatched++; $display("[TB] FAIL sw_done k%0d got %b want %b", k, done, (k == 4)); end
    end
    @(negedge clk);
    n_compared++; if (in_ready !== 1'b1 || done !== 1'b0) begin n_mismatched++; $display("[TB] FAIL sw_end got ready=%b done=%b want 1/0", in_ready, done); end
  endtask

  // Runs every scenario in order and reports the totals.
  initial begin
    test_reset();
    test_auto_sequence();
    test_manual();
    test_ignore_in_valid();
    test_reset_mid();
    test_mode_switch();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
